tc_to_signmag_serial: RTL and testbench
=======================================

Name: tc_to_signmag_serial

Overview:
- Bit-serial decoder that converts a WIDTH-bit two's-complement operand into sign-magnitude form (sign bit plus unsigned magnitude).
- It is the inverse path of the adder/subtractor's two's-complement negation stage and feeds results to display/readout logic.
- Conversion walks the operand LSB-first: bits are copied up to and including the first 1, and every later bit is inverted.
- Operands and results move over valid/ready handshakes.

Parameters:
- WIDTH, 4, operand and magnitude width in bits; minimum 2.
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_num holds an operand
- in_ready  output  1  block can accept an operand
- in_num  input  WIDTH  two's-complement operand
- out_valid  output  1  out_sign/out_mag hold a result
- out_ready  input  1  consumer accepts the result
- out_sign  output  1  1 = negative
- out_mag  output  WIDTH  unsigned magnitude

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, out_sign=0, out_mag=0.
  - Shift register, counter and seen_one all cleared.
  - Takes effect immediately, mid-conversion included; the in-flight operand is discarded and no partial result is ever presented.
- States IDLE, CONVERT, DONE; 2-bit encoding.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch in_num into the shift register, sign_r=in_num[WIDTH-1], counter=0, seen_one=0, go to CONVERT.
- CONVERT:
  - in_ready=0, out_valid=0.
  - Each cycle, process b = shift register LSB:
    - m = b when sign_r=0 or seen_one=0.
    - m = ~b when sign_r=1 and seen_one=1.
    - seen_one <= seen_one | b.
  - Shift m into out_mag from the MSB end. Shift the operand register right. counter++.
  - Move to DONE on the edge where counter reaches WIDTH-1, i.e. after exactly WIDTH CONVERT cycles.
- DONE:
  - out_valid=1; out_sign=sign_r; out_mag holds the final magnitude.
  - Both are stable until the handshake completes.
  - On an edge with out_ready=1: out_valid drops and state goes to IDLE.
- Latency: operand accepted at edge T0 gives out_valid=1 from edge T0+WIDTH.
- Throughput: at best one operand per WIDTH+2 cycles. There is no accept in the same cycle as DONE (in_ready=0 in DONE and CONVERT).
- Positive and zero operands still take the full WIDTH cycles; latency is fixed and never data-dependent.
- Most-negative operand (100..0): out_sign=1, out_mag=100..0 (2^(WIDTH-1) as unsigned). This is a valid result with no overflow flag.
- Zero: out_sign=0, out_mag=0. Negative zero is never produced.
- in_valid asserted outside IDLE is ignored; the upstream holds the operand until in_ready.
- out_ready already high when DONE is entered: the handshake completes on the next edge, so out_valid is high for exactly one cycle.
- out_ready toggling while out_valid=0 has no effect.
- Outputs are registered. in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.

Decomposition:
- Shared package holds:
  - state localparams ST_IDLE=2'd0, ST_CONVERT=2'd1, ST_DONE=2'd2;
  - the default width constant ADDSUB_WIDTH=4, shared with the adder/subtractor blocks.
- One sub-module is natural: tc_serial_cell. It is a combinational per-bit negation cell with inputs b, sign, seen_one and outputs m, seen_one_next.
- FSM, counter and registers stay in the top.

Test Plan (WIDTH=4):
- in_num=4'b0101 (+5), out_ready=1 → out_valid at T0+4; out_sign=0, out_mag=4'b0101; out_valid high for one cycle; in_ready=1 one cycle later.
- in_num=4'b1011 (−5) → out_sign=1, out_mag=4'b0101. Then in_num=4'b1111 (−1) → out_sign=1, out_mag=4'b0001.
- in_num=4'b1000 (−8) → out_sign=1, out_mag=4'b1000. Then in_num=4'b0000 → out_sign=0, out_mag=4'b0000.
- Backpressure: out_ready=0 for 6 cycles after out_valid → out_sign/out_mag unchanged and in_ready=0 throughout. A second in_valid offered during that time is not accepted. On out_ready=1 the first result retires, then the second operand is accepted.
- Reset mid-op: drop rst_n asynchronously during the 2nd CONVERT cycle of −3 → in_ready=1, out_valid=0, out_mag=0 immediately. After release, +3 converts to sign=0, mag=0011.
- Exhaustive sweep of all 16 operands, back-to-back with out_ready=1 → every result matches the reference model (sign=in[3], mag=|value|) and the interval between accepts is exactly 6 cycles.

Source files
------------

// File: rtl/tc_to_signmag_serial_pkg.sv
// Shared constants for the two's-complement to sign-magnitude serial decoder.
// The default width is shared with the adder/subtractor blocks.
package tc_to_signmag_serial_pkg;

    localparam int ADDSUB_WIDTH = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        CONVERT = ST_CONVERT,
        DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/tc_to_signmag_serial_cell.sv
// Per-bit negation cell: copy bits up to and including the first 1, invert the rest.
// Inversion only applies to negative operands.
module tc_serial_cell (
    input  logic b,
    input  logic sign,
    input  logic seen_one,
    output logic m,
    output logic seen_one_next
);

    assign m             = (sign && seen_one) ? ~b : b;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/tc_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first.
// Latency is fixed at WIDTH cycles from accept to out_valid.
module tc_to_signmag_serial
    import tc_to_signmag_serial_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag
);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic               sign_r;
    logic [CNT_W-1:0]   cnt;
    logic               seen_one;
    logic               m;
    logic               seen_one_next;

    tc_serial_cell u_cell (
        .b            (shreg[0]),
        .sign         (sign_r),
        .seen_one     (seen_one),
        .m            (m),
        .seen_one_next(seen_one_next)
    );

    // Handshake flags come straight from the state register, never from in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            sign_r   <= 1'b0;
            cnt      <= '0;
            seen_one <= 1'b0;
            out_sign <= 1'b0;
            out_mag  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_num;
                        sign_r   <= in_num[WIDTH-1];
                        cnt      <= '0;
                        seen_one <= 1'b0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Magnitude fills from the MSB end so the first bit processed lands at bit 0.
                    out_mag  <= {m, out_mag[WIDTH-1:1]};
                    shreg    <= shreg >> 1;
                    seen_one <= seen_one_next;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        out_sign <= sign_r;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_to_signmag_serial.sv
// Self-checking bench for tc_to_signmag_serial: directed cases, full sweep and random operands
// compared against an arithmetic sign/absolute-value model.
module tb_tc_to_signmag_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_num;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;

    int  vectors;
    int  miscompares;
    time lastAccept;
    time acceptTime;

    tc_to_signmag_serial #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_num   (in_num),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sign (out_sign),
        .out_mag  (out_mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] refMag(input logic [W-1:0] n);
        int v;
        v = $signed(n);
        if (v < 0) v = -v;
        return W'(v);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold>0 applies backpressure and can offer a second operand meanwhile.
    task automatic applyStimulus(input logic [W-1:0] num, input int hold, input bit offer,
                                 input logic [W-1:0] nextNum, input bit checkInterval);
        int waitCnt;
        logic         expSign;
        logic [W-1:0] expMag;
        expSign = num[W-1];
        expMag  = refMag(num);
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 20) checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_num    = num;
        @(posedge clk);
        acceptTime = $time;
        if (checkInterval) checkOutput("accept_interval", 32'((acceptTime - lastAccept) / 10), 32'd6);
        lastAccept = acceptTime;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < W; k++) begin
            checkOutput("out_valid_early", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        checkOutput("out_valid_latency", {31'd0, out_valid}, 32'd1);
        checkOutput("out_sign", {31'd0, out_sign}, {31'd0, expSign});
        checkOutput("out_mag", {28'd0, out_mag}, {28'd0, expMag});
        for (int h = 0; h < hold; h++) begin
            if (offer) begin
                in_valid = 1'b1;
                in_num   = nextNum;
            end
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_sign", {31'd0, out_sign}, {31'd0, expSign});
            checkOutput("hold_mag", {28'd0, out_mag}, {28'd0, expMag});
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("retire_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("retire_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        lastAccept  = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_num      = '0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_sign", {31'd0, out_sign}, 32'd0);
        checkOutput("reset_out_mag", {28'd0, out_mag}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(4'b0101, 0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b1011, 0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b1000, 0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 0, 1'b0, 4'b0000, 1'b0);

        applyStimulus(4'b0110, 6, 1'b1, 4'b1010, 1'b0);
        applyStimulus(4'b1010, 0, 1'b0, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of the second conversion cycle of -3.
        in_valid = 1'b1;
        in_num   = 4'b1101;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset_out_mag", {28'd0, out_mag}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'b0011, 0, 1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(W'(i), 0, 1'b0, 4'b0000, i > 0);
        end

        for (int r = 0; r < 24; r++) begin
            applyStimulus(W'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, 4'b0000, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
